id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_id_stage.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Summary  : MIPS-subset decode stage. Latches the fetched instruction, decodes
//            it into ALU/memory controls, stalls on register hazards and
//            resolves branches/jumps. Define ID_BYPASS_EN to forward ES/MS
//            results instead of stalling (loads in ES still stall).
//            ds_alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL.
// Revision : 1.0  initial release
// ============================================================================
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] inst_sram_rdata,
    output logic        ds_allowin,
    output logic [1:0]  br_jen,
    output logic [31:0] br_offset,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        es_valid,
    input  logic [4:0]  es_dest,
    input  logic        es_is_load,
    input  logic [31:0] es_result,
    input  logic        ms_valid,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [3:0]  ds_alu_op,
    output logic [31:0] ds_src1,
    output logic [31:0] ds_src2,
    output logic [4:0]  ds_dest,
    output logic        ds_mem_we,
    output logic        ds_mem_re,
    output logic [31:0] ds_st_data,
    output logic [31:0] ds_pc,
    output logic        ds_inst_invalid
);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_ADDIU   = 6'h09;
    localparam logic [5:0] c_OP_LUI     = 6'h0f;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2b;

    localparam logic [5:0] c_FN_SLL     = 6'h00;
    localparam logic [5:0] c_FN_JR      = 6'h08;
    localparam logic [5:0] c_FN_ADDU    = 6'h21;
    localparam logic [5:0] c_FN_SUBU    = 6'h23;
    localparam logic [5:0] c_FN_AND     = 6'h24;
    localparam logic [5:0] c_FN_OR      = 6'h25;
    localparam logic [5:0] c_FN_XOR     = 6'h26;
    localparam logic [5:0] c_FN_SLT     = 6'h2a;
    localparam logic [5:0] c_FN_SLTU    = 6'h2b;

    localparam logic [3:0] c_ALU_ADD    = 4'd0;
    localparam logic [3:0] c_ALU_SUB    = 4'd1;
    localparam logic [3:0] c_ALU_AND    = 4'd2;
    localparam logic [3:0] c_ALU_OR     = 4'd3;
    localparam logic [3:0] c_ALU_XOR    = 4'd4;
    localparam logic [3:0] c_ALU_SLT    = 4'd5;
    localparam logic [3:0] c_ALU_SLTU   = 4'd6;
    localparam logic [3:0] c_ALU_SLL    = 4'd7;

    localparam logic [1:0] c_BR_NONE    = 2'b00;
    localparam logic [1:0] c_BR_REL     = 2'b01;
    localparam logic [1:0] c_BR_ABS     = 2'b10;
    localparam logic [1:0] c_BR_REG     = 2'b11;

    logic        r_ds_valid;
    logic [31:0] r_ds_pc;
    logic [31:0] r_ds_inst;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sa;
    logic [15:0] w_imm;
    logic [25:0] w_target;
    logic [31:0] w_simm;

    logic        w_rs_es_hit;
    logic        w_rs_ms_hit;
    logic        w_rt_es_hit;
    logic        w_rt_ms_hit;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_hazard;
    logic        w_ready_go;
    logic        w_fire;

    logic [3:0]  w_alu_op;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [4:0]  w_dest;
    logic        w_mem_we;
    logic        w_mem_re;
    logic        w_invalid;
    logic        w_use_rs;
    logic        w_use_rt;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_j;
    logic        w_is_jr;

    logic [3:0]  w_pc4_hi;
    logic [27:0] w_unused_pc4_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ds_valid <= 1'b0;
            r_ds_pc    <= RESET_PC;
            r_ds_inst  <= 32'd0;
        end else if (ds_allowin) begin
            r_ds_valid <= fs_valid;
            if (fs_valid) begin
                r_ds_pc   <= fs_pc;
                r_ds_inst <= inst_sram_rdata;
            end
        end
    end

    assign w_op     = r_ds_inst[31:26];
    assign w_rs     = r_ds_inst[25:21];
    assign w_rt     = r_ds_inst[20:16];
    assign w_rd     = r_ds_inst[15:11];
    assign w_sa     = r_ds_inst[10:6];
    assign w_funct  = r_ds_inst[5:0];
    assign w_imm    = r_ds_inst[15:0];
    assign w_target = r_ds_inst[25:0];
    assign w_simm   = {{16{w_imm[15]}}, w_imm};

    assign rf_raddr1 = w_rs;
    assign rf_raddr2 = w_rt;

    // Producer matches ignore whether the operand is used; the hazard term gates that.
    assign w_rs_es_hit = (w_rs != 5'd0) && es_valid && (es_dest == w_rs);
    assign w_rs_ms_hit = (w_rs != 5'd0) && ms_valid && (ms_dest == w_rs);
    assign w_rt_es_hit = (w_rt != 5'd0) && es_valid && (es_dest == w_rt);
    assign w_rt_ms_hit = (w_rt != 5'd0) && ms_valid && (ms_dest == w_rt);

`ifdef ID_BYPASS_EN
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 :
                      w_rs_es_hit    ? es_result :
                      w_rs_ms_hit    ? ms_result : rf_rdata1;
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 :
                      w_rt_es_hit    ? es_result :
                      w_rt_ms_hit    ? ms_result : rf_rdata2;
    assign w_hazard = r_ds_valid && es_is_load &&
                      ((w_use_rs && w_rs_es_hit) || (w_use_rt && w_rt_es_hit));
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{es_is_load, es_result, ms_result};
    assign w_rs_val = (w_rs == 5'd0) ? 32'd0 : rf_rdata1;
    assign w_rt_val = (w_rt == 5'd0) ? 32'd0 : rf_rdata2;
    assign w_hazard = r_ds_valid &&
                      ((w_use_rs && (w_rs_es_hit || w_rs_ms_hit)) ||
                       (w_use_rt && (w_rt_es_hit || w_rt_ms_hit)));
`endif

    always_comb begin
        w_alu_op  = c_ALU_ADD;
        w_src1    = w_rs_val;
        w_src2    = w_rt_val;
        w_dest    = 5'd0;
        w_mem_we  = 1'b0;
        w_mem_re  = 1'b0;
        w_invalid = 1'b0;
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        w_is_jr   = 1'b0;
        case (w_op)
            c_OP_SPECIAL: begin
                w_dest   = w_rd;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                case (w_funct)
                    c_FN_ADDU: w_alu_op = c_ALU_ADD;
                    c_FN_SUBU: w_alu_op = c_ALU_SUB;
                    c_FN_AND:  w_alu_op = c_ALU_AND;
                    c_FN_OR:   w_alu_op = c_ALU_OR;
                    c_FN_XOR:  w_alu_op = c_ALU_XOR;
                    c_FN_SLT:  w_alu_op = c_ALU_SLT;
                    c_FN_SLTU: w_alu_op = c_ALU_SLTU;
                    c_FN_SLL: begin
                        w_alu_op = c_ALU_SLL;
                        w_src1   = {27'd0, w_sa};
                        w_use_rs = 1'b0;
                    end
                    c_FN_JR: begin
                        w_dest   = 5'd0;
                        w_use_rt = 1'b0;
                        w_is_jr  = 1'b1;
                    end
                    default: begin
                        w_invalid = 1'b1;
                        w_dest    = 5'd0;
                        w_use_rs  = 1'b0;
                        w_use_rt  = 1'b0;
                    end
                endcase
            end
            c_OP_ADDIU: begin
                w_dest   = w_rt;
                w_use_rs = 1'b1;
                w_src2   = w_simm;
            end
            c_OP_LUI: begin
                w_dest = w_rt;
                w_src1 = 32'd0;
                w_src2 = {w_imm, 16'h0000};
            end
            c_OP_LW: begin
                w_dest   = w_rt;
                w_use_rs = 1'b1;
                w_src2   = w_simm;
                w_mem_re = 1'b1;
            end
            c_OP_SW: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_src2   = w_simm;
                w_mem_we = 1'b1;
            end
            c_OP_BEQ: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_is_beq = 1'b1;
            end
            c_OP_BNE: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_is_bne = 1'b1;
            end
            c_OP_J: w_is_j = 1'b1;
            c_OP_JAL: begin
                w_is_j = 1'b1;
                w_dest = 5'd31;
                w_src1 = r_ds_pc + 32'd8;
                w_src2 = 32'd0;
            end
            default: w_invalid = 1'b1;
        endcase
    end

    assign w_ready_go     = !w_hazard;
    assign ds_allowin     = !r_ds_valid || (w_ready_go && es_allowin);
    assign ds_to_es_valid = r_ds_valid && w_ready_go;
    assign w_fire         = ds_to_es_valid && es_allowin;

    assign {w_pc4_hi, w_unused_pc4_lo} = r_ds_pc + 32'd4;

    // Redirect is only issued in the cycle the branch hands off to execute.
    always_comb begin
        br_jen    = c_BR_NONE;
        br_offset = 32'd0;
        if (w_fire) begin
            if ((w_is_beq && (w_rs_val == w_rt_val)) ||
                (w_is_bne && (w_rs_val != w_rt_val))) begin
                br_jen    = c_BR_REL;
                br_offset = {w_simm[29:0], 2'b00};
            end else if (w_is_j) begin
                br_jen    = c_BR_ABS;
                br_offset = {w_pc4_hi, w_target, 2'b00};
            end else if (w_is_jr) begin
                br_jen    = c_BR_REG;
                br_offset = w_rs_val;
            end
        end
    end

    assign ds_alu_op       = w_alu_op;
    assign ds_src1         = w_src1;
    assign ds_src2         = w_src2;
    assign ds_dest         = w_dest;
    assign ds_mem_we       = w_mem_we;
    assign ds_mem_re       = w_mem_re;
    assign ds_st_data      = w_rt_val;
    assign ds_pc           = r_ds_pc;
    assign ds_inst_invalid = w_invalid;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Summary  : Self-checking bench for id_stage: directed scenarios followed by
//            randomized traffic against a mnemonic-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_stage;

    localparam logic [31:0] c_RESET_PC = 32'hbfc00000;
    localparam logic [3:0]  c_ALU_ADD  = 4'd0;
    localparam logic [3:0]  c_ALU_SUB  = 4'd1;
    localparam logic [3:0]  c_ALU_AND  = 4'd2;
    localparam logic [3:0]  c_ALU_OR   = 4'd3;
    localparam logic [3:0]  c_ALU_XOR  = 4'd4;
    localparam logic [3:0]  c_ALU_SLT  = 4'd5;
    localparam logic [3:0]  c_ALU_SLTU = 4'd6;
    localparam logic [3:0]  c_ALU_SLL  = 4'd7;

    typedef enum logic [4:0] {
        M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLTU, M_SLL, M_JR,
        M_ADDIU, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_JAL, M_BAD, M_BADR
    } mn_e;

    typedef struct packed {
        mn_e         mn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [25:0] tgt;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs_valid;
    logic [31:0] fs_pc;
    logic [31:0] inst_sram_rdata;
    logic        ds_allowin;
    logic [1:0]  br_jen;
    logic [31:0] br_offset;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata1;
    logic [31:0] rf_rdata2;
    logic        es_valid;
    logic [4:0]  es_dest;
    logic        es_is_load;
    logic [31:0] es_result;
    logic        ms_valid;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [3:0]  ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [4:0]  ds_dest;
    logic        ds_mem_we;
    logic        ds_mem_re;
    logic [31:0] ds_st_data;
    logic [31:0] ds_pc;
    logic        ds_inst_invalid;

    logic [31:0] regs [32];
    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state: what decode should be holding
    logic        m_valid;
    logic [31:0] m_pc;
    ins_t        m_ins;
    ins_t        f_ins;
    logic        e_allowin;

    always #5 clk = ~clk;

    id_stage #(.RESET_PC(c_RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .fs_valid(fs_valid), .fs_pc(fs_pc), .inst_sram_rdata(inst_sram_rdata),
        .ds_allowin(ds_allowin), .br_jen(br_jen), .br_offset(br_offset),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .es_valid(es_valid), .es_dest(es_dest), .es_is_load(es_is_load),
        .es_result(es_result), .ms_valid(ms_valid), .ms_dest(ms_dest),
        .ms_result(ms_result), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_alu_op(ds_alu_op),
        .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_dest(ds_dest),
        .ds_mem_we(ds_mem_we), .ds_mem_re(ds_mem_re), .ds_st_data(ds_st_data),
        .ds_pc(ds_pc), .ds_inst_invalid(ds_inst_invalid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encode(input ins_t i);
        case (i.mn)
            M_ADDU:  return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h21};
            M_SUBU:  return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h23};
            M_AND:   return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h24};
            M_OR:    return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h25};
            M_XOR:   return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h26};
            M_SLT:   return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h2a};
            M_SLTU:  return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h2b};
            M_SLL:   return {6'h00, 5'd0, i.rt, i.rd, i.sa, 6'h00};
            M_JR:    return {6'h00, i.rs, 15'd0, 6'h08};
            M_ADDIU: return {6'h09, i.rs, i.rt, i.imm};
            M_LUI:   return {6'h0f, 5'd0, i.rt, i.imm};
            M_LW:    return {6'h23, i.rs, i.rt, i.imm};
            M_SW:    return {6'h2b, i.rs, i.rt, i.imm};
            M_BEQ:   return {6'h04, i.rs, i.rt, i.imm};
            M_BNE:   return {6'h05, i.rs, i.rt, i.imm};
            M_J:     return {6'h02, i.tgt};
            M_JAL:   return {6'h03, i.tgt};
            M_BADR:  return {6'h00, i.rs, i.rt, i.rd, 5'd0, 6'h3f};
            default: return {6'h3f, i.tgt};
        endcase
    endfunction

    function automatic ins_t mk(input mn_e m, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [15:0] imm,
                                input logic [25:0] tgt);
        ins_t i;
        i.mn = m; i.rs = rs; i.rt = rt; i.rd = rd; i.sa = 5'd0; i.imm = imm; i.tgt = tgt;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.mn  = mn_e'(5'($urandom_range(0, 18)));
        i.rs  = 5'($urandom_range(0, 7));
        i.rt  = 5'($urandom_range(0, 7));
        i.rd  = 5'($urandom_range(0, 7));
        i.sa  = 5'($urandom);
        i.imm = 16'($urandom);
        i.tgt = 26'($urandom);
        return i;
    endfunction

    function automatic bit reads_rs(input mn_e m);
        return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLTU, M_JR,
                         M_ADDIU, M_LW, M_SW, M_BEQ, M_BNE};
    endfunction

    function automatic bit reads_rt(input mn_e m);
        return m inside {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLTU, M_SLL,
                         M_SW, M_BEQ, M_BNE};
    endfunction

    function automatic logic [3:0] alu_code(input mn_e m);
        case (m)
            M_SUBU:  return c_ALU_SUB;
            M_AND:   return c_ALU_AND;
            M_OR:    return c_ALU_OR;
            M_XOR:   return c_ALU_XOR;
            M_SLT:   return c_ALU_SLT;
            M_SLTU:  return c_ALU_SLTU;
            M_SLL:   return c_ALU_SLL;
            default: return c_ALU_ADD;
        endcase
    endfunction

    // Architectural value of a source register as decode should see it
    function automatic logic [31:0] opval(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (es_valid && es_dest == r) return es_result;
        if (ms_valid && ms_dest == r) return ms_result;
`endif
        return regs[r];
    endfunction

    function automatic bit blocks(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
`ifdef ID_BYPASS_EN
        return es_valid && es_is_load && es_dest == r;
`else
        return (es_valid && es_dest == r) || (ms_valid && ms_dest == r);
`endif
    endfunction

    task automatic check_outputs();
        logic [31:0] rsv, rtv, sext, pc4, e_off, e_s1, e_s2;
        logic [1:0]  e_jen;
        logic [4:0]  e_dest;
        logic [3:0]  e_op;
        bit          hz, go, fire, e_we, e_re, e_inv, c_op, c_s1, c_s2;
        rsv  = opval(m_ins.rs);
        rtv  = opval(m_ins.rt);
        sext = {{16{m_ins.imm[15]}}, m_ins.imm};
        pc4  = m_pc + 32'd4;
        hz   = m_valid && ((reads_rs(m_ins.mn) && blocks(m_ins.rs)) ||
                           (reads_rt(m_ins.mn) && blocks(m_ins.rt)));
        go   = !hz;
        e_allowin = !m_valid || (go && es_allowin);
        fire = m_valid && go && es_allowin;
        check("allowin", ds_allowin, e_allowin);
        check("to_es_valid", ds_to_es_valid, m_valid && go);
        e_jen = 2'b00;
        e_off = 32'd0;
        if (fire) begin
            case (m_ins.mn)
                M_BEQ: if (rsv == rtv) begin e_jen = 2'b01; e_off = sext << 2; end
                M_BNE: if (rsv != rtv) begin e_jen = 2'b01; e_off = sext << 2; end
                M_J, M_JAL: begin
                    e_jen = 2'b10;
                    e_off = (pc4 & 32'hf000_0000) | ({6'd0, m_ins.tgt} << 2);
                end
                M_JR: begin e_jen = 2'b11; e_off = rsv; end
                default: ;
            endcase
        end
        check("br_jen", br_jen, e_jen);
        if (e_jen != 2'b00) check("br_offset", br_offset, e_off);
        if (m_valid) begin
            check("ds_pc", ds_pc, m_pc);
            if (reads_rs(m_ins.mn)) check("raddr1", rf_raddr1, m_ins.rs);
            if (reads_rt(m_ins.mn)) check("raddr2", rf_raddr2, m_ins.rt);
            e_dest = 5'd0; e_we = 0; e_re = 0; e_inv = 0;
            c_op = 0; c_s1 = 0; c_s2 = 0;
            e_op = c_ALU_ADD; e_s1 = 32'd0; e_s2 = 32'd0;
            case (m_ins.mn)
                M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLTU: begin
                    e_dest = m_ins.rd; e_op = alu_code(m_ins.mn);
                    c_op = 1; c_s1 = 1; c_s2 = 1; e_s1 = rsv; e_s2 = rtv;
                end
                M_SLL: begin
                    e_dest = m_ins.rd; e_op = c_ALU_SLL;
                    c_op = 1; c_s1 = 1; c_s2 = 1; e_s1 = {27'd0, m_ins.sa}; e_s2 = rtv;
                end
                M_ADDIU, M_LW: begin
                    e_dest = m_ins.rt; e_re = (m_ins.mn == M_LW);
                    c_op = 1; c_s1 = 1; c_s2 = 1; e_s1 = rsv; e_s2 = sext;
                end
                M_SW: begin
                    e_we = 1;
                    c_op = 1; c_s1 = 1; c_s2 = 1; e_s1 = rsv; e_s2 = sext;
                    check("st_data", ds_st_data, rtv);
                end
                M_LUI: begin
                    e_dest = m_ins.rt; c_s2 = 1; e_s2 = {m_ins.imm, 16'h0000};
                end
                M_JAL: begin
                    e_dest = 5'd31;
                    c_op = 1; c_s1 = 1; c_s2 = 1; e_s1 = m_pc + 32'd8; e_s2 = 32'd0;
                end
                M_BAD, M_BADR: e_inv = 1;
                default: ;
            endcase
            check("dest", ds_dest, e_dest);
            check("mem_we", ds_mem_we, e_we);
            check("mem_re", ds_mem_re, e_re);
            check("invalid", ds_inst_invalid, e_inv);
            if (c_op) check("alu_op", ds_alu_op, e_op);
            if (c_s1) check("src1", ds_src1, e_s1);
            if (c_s2) check("src2", ds_src2, e_s2);
        end
    endtask

    task automatic present(input ins_t i, input logic [31:0] pc, input logic v);
        f_ins           = i;
        inst_sram_rdata = encode(i);
        fs_pc           = pc;
        fs_valid        = v;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc    = c_RESET_PC;
        m_ins   = mk(M_SLL, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    endtask

    task automatic settle();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        if (e_allowin) begin
            m_valid = fs_valid;
            if (fs_valid) begin
                m_pc  = fs_pc;
                m_ins = f_ins;
            end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_allowin"}, ds_allowin, 32'd1);
        check({tag, "_to_es"}, ds_to_es_valid, 32'd0);
        check({tag, "_br_jen"}, br_jen, 32'd0);
        check({tag, "_pc"}, ds_pc, c_RESET_PC);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        es_valid = 0; es_dest = 0; es_is_load = 0; es_result = 0;
        ms_valid = 0; ms_dest = 0; ms_result = 0; es_allowin = 1;
        present(mk(M_SLL, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0), 32'd0, 1'b0);
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'hdead_beef;
        model_reset();
        e_allowin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // ADDIU $2,$0,5 handed to execute the cycle after fetch
        present(mk(M_ADDIU, 5'd0, 5'd2, 5'd0, 16'd5, 26'd0), 32'hbfc00000, 1'b1);
        settle(); advance();
        fs_valid = 1'b0;
        settle();
        check("addiu_to_es", ds_to_es_valid, 32'd1);
        check("addiu_src2", ds_src2, 32'd5);
        check("addiu_dest", ds_dest, 32'd2);
        check("addiu_br_jen", br_jen, 32'd0);
        advance();

        // BEQ $1,$1 taken for one cycle; delay slot still issues
        present(mk(M_BEQ, 5'd1, 5'd1, 5'd0, 16'h0004, 26'd0), 32'hbfc00004, 1'b1);
        settle(); advance();
        present(mk(M_ADDU, 5'd1, 5'd1, 5'd4, 16'd0, 26'd0), 32'hbfc00008, 1'b1);
        settle();
        check("beq_br_jen", br_jen, 32'd1);
        check("beq_offset", br_offset, 32'h10);
        advance();
        fs_valid = 1'b0;
        settle();
        check("slot_br_jen", br_jen, 32'd0);
        check("slot_to_es", ds_to_es_valid, 32'd1);
        check("slot_pc", ds_pc, 32'hbfc00008);
        advance();

        // JR $31 and JAL
        regs[31] = 32'hbfc00100;
        present(mk(M_JR, 5'd31, 5'd0, 5'd0, 16'd0, 26'd0), 32'hbfc00010, 1'b1);
        settle(); advance();
        fs_valid = 1'b0;
        settle();
        check("jr_br_jen", br_jen, 32'd3);
        check("jr_offset", br_offset, 32'hbfc00100);
        advance();
        present(mk(M_JAL, 5'd0, 5'd0, 5'd0, 16'd0, 26'h3000040), 32'hbfc00000, 1'b1);
        settle(); advance();
        fs_valid = 1'b0;
        settle();
        check("jal_br_jen", br_jen, 32'd2);
        check("jal_offset", br_offset, 32'hbc000100);
        check("jal_link", ds_src1, 32'hbfc00008);
        advance();

        // ADDU $3,$2,$2 against an ES producer of $2
        present(mk(M_ADDU, 5'd2, 5'd2, 5'd3, 16'd0, 26'd0), 32'hbfc00020, 1'b1);
        settle(); advance();
        fs_valid = 1'b0;
        es_valid = 1'b1; es_dest = 5'd2; es_result = 32'd7; es_is_load = 1'b0;
`ifdef ID_BYPASS_EN
        settle();
        check("fwd_to_es", ds_to_es_valid, 32'd1);
        check("fwd_src1", ds_src1, 32'd7);
        check("fwd_src2", ds_src2, 32'd7);
        advance();
`else
        for (int k = 0; k < 2; k++) begin
            settle();
            check("stall_allowin", ds_allowin, 32'd0);
            check("stall_to_es", ds_to_es_valid, 32'd0);
            advance();
        end
        es_valid = 1'b0;
        settle();
        check("unstall_to_es", ds_to_es_valid, 32'd1);
        advance();
`endif
        es_valid = 1'b0;

        // Backpressure on a taken branch, then reset mid-stall
        present(mk(M_BEQ, 5'd1, 5'd1, 5'd0, 16'h0008, 26'd0), 32'hbfc00030, 1'b1);
        settle(); advance();
        es_allowin = 1'b0;
        present(mk(M_ADDIU, 5'd1, 5'd5, 5'd0, 16'd9, 26'd0), 32'hbfc00034, 1'b1);
        for (int k = 0; k < 2; k++) begin
            settle();
            check("bp_allowin", ds_allowin, 32'd0);
            check("bp_br_jen", br_jen, 32'd0);
            check("bp_pc", ds_pc, 32'hbfc00030);
            advance();
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs("midrst");
        model_reset();
        settle();
        @(posedge clk);
        #1 rst = 1'b0;
        es_allowin = 1'b1;
        fs_valid = 1'b0;

        for (int i = 1; i < 8; i++) regs[i] = $urandom_range(0, 3);
        for (int c = 0; c < 2000; c++) begin
            present(rand_ins(), $urandom, $urandom_range(0, 3) != 0);
            es_valid   = $urandom_range(0, 1) != 0;
            es_dest    = 5'($urandom_range(0, 7));
            es_is_load = $urandom_range(0, 3) == 0;
            es_result  = $urandom;
            ms_valid   = $urandom_range(0, 1) != 0;
            ms_dest    = 5'($urandom_range(0, 7));
            ms_result  = $urandom;
            es_allowin = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 15) == 0) regs[$urandom_range(1, 7)] = $urandom_range(0, 3);
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
